// File: rtl/ultrasonic_scheduler_if.sv
// Result port from the scheduler to the serial formatter: one valid/ready
// handshake that carries the sensor index, the echo width and a timeout flag.
interface ultrasonic_scheduler_if #(
  parameter int WIDTH = 24
);
  logic             valid;
  logic             ready;
  logic [2:0]       id;
  logic [WIDTH-1:0] width;
  logic             timeout;

  modport master (output valid, id, width, timeout, input ready);
  modport slave  (input valid, id, width, timeout, output ready);
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic sensor scheduler: triggers one sensor at a time,
// times its echo with timeout protection and reports over a valid/ready port.
//
// state     | meaning
// IDLE      | waiting for enable and a non-empty mask
// TRIG      | trigger pulse on the selected sensor
// WAIT_RISE | waiting for the echo rising edge, bounded by the timeout
// MEASURE   | counting echo high time, saturating at the timeout
// REPORT    | result presented, held until accepted
// GAP       | quiet time before the next selection
module ultrasonic_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 800,
  parameter int TIMEOUT_CYCLES = 2_400_000,
  parameter int GAP_CYCLES     = 4_800_000,
  parameter int WIDTH          = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  output logic [N_SENSORS-1:0] trig,
  input  logic [N_SENSORS-1:0] echo,
  output logic                 busy,
  ultrasonic_scheduler_if.master res
);

  localparam int SEL_W   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int CNT_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES)
                         ? ((TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES)
                         : ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_t;

  state_t               state, state_n;
  logic [SEL_W-1:0]     sel, last, next_sel, idx;
  logic                 found;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_zero;
  logic [WIDTH-1:0]     width_q;
  logic                 timeout_q;
  logic [N_SENSORS-1:0] echo_m, echo_s;
  logic                 echo_prev, echo_sel, rise, width_at_limit;
  logic [N_SENSORS-1:0] trig_n;

  assign echo_sel       = echo_s[sel];
  assign rise           = echo_sel & ~echo_prev;
  assign cnt_zero       = (cnt == '0);
  assign width_at_limit = (width_q == WIDTH'(TIMEOUT_CYCLES));

  // Lowest set mask bit strictly above `last`, wrapping around.
  always_comb begin
    next_sel = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_SENSORS; k++) begin
      idx = SEL_W'((int'(last) + k) % N_SENSORS);
      if (!found && sensor_mask[idx]) begin
        found    = 1'b1;
        next_sel = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (enable && found) state_n = TRIG;
      TRIG:      if (cnt_zero) state_n = WAIT_RISE;
      WAIT_RISE: if (rise) state_n = MEASURE;
                 else if (cnt_zero) state_n = REPORT;
      MEASURE:   if (!echo_sel || width_at_limit) state_n = REPORT;
      REPORT:    if (res.ready) state_n = GAP;
      GAP:       if (cnt_zero) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res.valid = (state == REPORT);
    trig_n    = '0;
    if (state_n == TRIG) trig_n[(state == IDLE) ? next_sel : sel] = 1'b1;
  end

  assign res.id      = 3'(sel);
  assign res.width   = width_q;
  assign res.timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_m    <= '0;
      echo_s    <= '0;
      echo_prev <= 1'b0;
      trig      <= '0;
      sel       <= '0;
      last      <= SEL_W'(N_SENSORS - 1);
      cnt       <= '0;
      width_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      echo_m    <= echo;
      echo_s    <= echo_m;
      echo_prev <= echo_sel;
      trig      <= trig_n;
      case (state)
        IDLE: if (state_n == TRIG) begin
          sel       <= next_sel;
          cnt       <= CNT_W'(TRIG_CYCLES - 1);
          width_q   <= '0;
          timeout_q <= 1'b0;
        end
        TRIG: cnt <= cnt_zero ? CNT_W'(TIMEOUT_CYCLES - 1) : cnt - CNT_W'(1);
        WAIT_RISE: begin
          if (rise)          width_q   <= WIDTH'(1);
          else if (cnt_zero) timeout_q <= 1'b1;
          else               cnt       <= cnt - CNT_W'(1);
        end
        // Width stops at the limit; a still-high echo then reports as timeout.
        MEASURE: if (echo_sel) begin
          if (width_at_limit) timeout_q <= 1'b1;
          else                width_q   <= width_q + WIDTH'(1);
        end
        REPORT: if (res.ready) begin
          last <= sel;
          cnt  <= CNT_W'(GAP_CYCLES - 1);
        end
        GAP: if (!cnt_zero) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler: expected results are queued when a
// measurement is stimulated and compared when the result handshake occurs.
module tb_ultrasonic_scheduler;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int TO = 64;
  localparam int GC = 8;
  localparam int W  = 8;

  typedef struct packed {
    logic [2:0]   id;
    logic [W-1:0] width;
    logic         timeout;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_mask;
  logic [N-1:0] trig;
  logic [N-1:0] echo;
  logic         busy;

  ultrasonic_scheduler_if #(.WIDTH(W)) res_if ();

  ultrasonic_scheduler #(
    .N_SENSORS(N), .TRIG_CYCLES(TC), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GC), .WIDTH(W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .trig(trig), .echo(echo), .busy(busy), .res(res_if)
  );

  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   results    = 0;
  int   cyc        = 0;
  int   trig_start = 0;
  res_t sb[$];
  int   ids[5] = '{0, 1, 3, 0, 1};

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: sampled mid-cycle so the handshake seen here is the one the next edge takes.
  always @(negedge clk) begin
    res_t e;
    #2;
    if (!reset) begin
      check("trig_onehot0", 32'($onehot0(trig)), 1);
      if (res_if.valid && res_if.ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_id", 32'(res_if.id), 32'(e.id));
          check("res_width", 32'(res_if.width), 32'(e.width));
          check("res_timeout", 32'(res_if.timeout), 32'(e.timeout));
        end
        results++;
      end
    end
  end

  task automatic push(input int id, input int width, input int to);
    res_t e;
    e.id      = 3'(id);
    e.width   = W'(width);
    e.timeout = to[0];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for a trigger, checks its channel and length; returns at the first cycle after it.
  task automatic wait_trig(input int ch);
    int n;
    n = 0;
    while (trig == '0 && n < 500) begin @(negedge clk); n++; end
    check("trig_seen", 32'(trig != '0), 1);
    check("trig_channel", 32'(trig), 32'(1) << ch);
    trig_start = cyc;
    n = 0;
    while (trig != '0 && n < 100) begin @(negedge clk); n++; end
    check("trig_length", n, TC);
  endtask

  task automatic echo_pulse(input int ch, input int delay, input int hold);
    repeat (delay) @(negedge clk);
    echo[ch] = 1'b1;
    repeat (hold) @(negedge clk);
    echo[ch] = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_if.valid && lat < 300) begin @(negedge clk); lat++; end
    check("valid_seen", 32'(res_if.valid), 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    check("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, prev_start, n;
    reset        = 1'b1;
    enable       = 1'b0;
    sensor_mask  = '0;
    echo         = '0;
    res_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_trig", 32'(trig), 0);
    check("rst_valid", 32'(res_if.valid), 0);
    check("rst_id", 32'(res_if.id), 0);
    check("rst_width", 32'(res_if.width), 0);
    check("rst_timeout", 32'(res_if.timeout), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // single echo
    sensor_mask = 4'b0001;
    enable      = 1'b1;
    wait_trig(0);
    enable = 1'b0;
    push(0, 20, 0);
    echo_pulse(0, 10, 20);
    wait_idle(200);

    // round robin from a fresh reset
    do_reset();
    sensor_mask = 4'b1011;
    enable      = 1'b1;
    prev_start  = 0;
    for (int k = 0; k < 5; k++) begin
      wait_trig(ids[k]);
      if (k > 0) check("rr_spacing", 32'((trig_start - prev_start) >= TC + 5 + GC), 1);
      prev_start = trig_start;
      if (k == 4) enable = 1'b0;
      push(ids[k], 5, 0);
      echo_pulse(ids[k], 3, 5);
    end
    wait_idle(200);

    // no echo
    sensor_mask = 4'b0100;
    enable      = 1'b1;
    wait_trig(2);
    enable = 1'b0;
    push(2, 0, 1);
    wait_valid(lat);
    check("timeout_latency", 32'(lat == TO || lat == TO + 1), 1);
    wait_idle(200);

    // stuck echo, then over-long echo
    sensor_mask = 4'b0001;
    echo[0]     = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_trig(0);
    enable = 1'b0;
    push(0, 0, 1);
    wait_idle(300);
    echo[0] = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_trig(0);
    enable = 1'b0;
    push(0, TO, 1);
    echo_pulse(0, 3, 200);
    wait_idle(300);

    // backpressure
    sensor_mask  = 4'b0010;
    res_if.ready = 1'b0;
    enable       = 1'b1;
    wait_trig(1);
    enable = 1'b0;
    push(1, 7, 0);
    echo_pulse(1, 2, 7);
    wait_valid(lat);
    for (int i = 0; i < 30; i++) begin
      check("bp_valid", 32'(res_if.valid), 1);
      check("bp_id", 32'(res_if.id), 1);
      check("bp_width", 32'(res_if.width), 7);
      check("bp_timeout", 32'(res_if.timeout), 0);
      check("bp_trig", 32'(trig), 0);
      @(negedge clk);
    end
    res_if.ready = 1'b1;
    @(negedge clk);
    check("valid_drop", 32'(res_if.valid), 0);
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    check("gap_length", n, GC);

    // reset during MEASURE, then enable low and empty mask
    sensor_mask = 4'b1001;
    enable      = 1'b1;
    wait_trig(3);
    echo[3] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_trig", 32'(trig), 0);
    check("mrst_valid", 32'(res_if.valid), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_id", 32'(res_if.id), 0);
    check("mrst_width", 32'(res_if.width), 0);
    reset   = 1'b0;
    echo[3] = 1'b0;
    wait_trig(0);
    enable = 1'b0;
    push(0, 6, 0);
    echo_pulse(0, 1, 6);
    wait_idle(200);
    for (int i = 0; i < 20; i++) begin
      check("disabled_busy", 32'(busy), 0);
      check("disabled_trig", 32'(trig), 0);
      @(negedge clk);
    end
    sensor_mask = 4'b0000;
    enable      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("empty_mask_busy", 32'(busy), 0);
      check("empty_mask_trig", 32'(trig), 0);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    check("result_count", results, 11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
